// File: rtl/avl_uart_master.sv
// ---------------------------------------------------------------------------
// avl_uart_master
//
// Avalon-MM master that drives the slave port of avl_uart_interface for a
// streaming client. After reset it writes the UART config register (addr 3),
// then loops: poll status (addr 0), and based on the status either push one
// client TX word (addr 1), pull one RX word (addr 2) into a one-entry output
// register, rewrite the config, or poll again.
//
// Ports:
//   avl_clk_i, avl_reset_ni       clock, asynchronous active-low reset
//   avl_address_o .. avl_read_o   Avalon-MM command outputs (word address < 4)
//   avl_readdata_i, avl_waitrequest_i, avl_readdatavalid_i  Avalon responses
//   tx_data_i/tx_valid_i/tx_ready_o  client TX word, ready pulses on capture
//   rx_data_o/rx_valid_o/rx_ready_i  received word held until consumed
//   cfg_data_i/cfg_load_i         request a config register rewrite
//   busy_o                        high whenever the FSM is not in POLL_RD
//   error_o                       sticky readdatavalid timeout flag
//
// Optional feature (macro AVL_RDV_TIMEOUT_EN): bounds each read wait to
// TIMEOUT cycles; on expiry error_o is set and polling restarts. Without the
// macro the FSM waits indefinitely and error_o is tied low.
// ---------------------------------------------------------------------------
module avl_uart_master #(
    parameter int          DATASIZE    = 20,
    parameter logic [31:0] CFG_DEFAULT = 32'h0000_01B2,
    parameter int          TIMEOUT     = 16
) (
    input  logic                avl_clk_i,
    input  logic                avl_reset_ni,
    output logic [13:0]         avl_address_o,
    output logic [3:0]          avl_byteenable_o,
    output logic [31:0]         avl_writedata_o,
    output logic                avl_write_o,
    output logic                avl_read_o,
    input  logic [31:0]         avl_readdata_i,
    input  logic                avl_waitrequest_i,
    input  logic                avl_readdatavalid_i,
    input  logic [DATASIZE-1:0] tx_data_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    output logic [DATASIZE-1:0] rx_data_o,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
    input  logic [31:0]         cfg_data_i,
    input  logic                cfg_load_i,
    output logic                busy_o,
    output logic                error_o
);

    typedef enum logic [2:0] {
        CFG_WR, POLL_RD, POLL_WAIT, DECIDE, TX_WR, RX_RD, RX_WAIT
    } state_t;

    localparam logic [13:0] ADDR_STATUS = 14'd0;
    localparam logic [13:0] ADDR_TX     = 14'd1;
    localparam logic [13:0] ADDR_RX     = 14'd2;
    localparam logic [13:0] ADDR_CFG    = 14'd3;

    state_t      state;
    logic [31:0] cfg_value;
    logic        cfg_pending;
    logic        tx_full;     // status bit 3, latched at the last poll
    logic        rx_avail;    // status bit 2, latched at the last poll
    logic        rr_rx;       // round-robin: 1 means RX wins the next tie
    logic        tx_elig;
    logic        rx_elig;

    assign tx_elig          = tx_valid_i && !tx_full;
    assign rx_elig          = rx_avail && !rx_valid_o;
    assign avl_byteenable_o = 4'hF;
    assign busy_o           = (state != POLL_RD);

    // Upper read-data bits carry nothing this master consumes.
    logic unused_readdata;
    assign unused_readdata = &{1'b0, avl_readdata_i[31:DATASIZE]};

`ifdef AVL_RDV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
`else
    assign error_o = 1'b0;
`endif

    // NOTE: every register here is updated with <= so all next-state values
    // are computed from the same pre-edge snapshot; blocking assignments would
    // make later statements see half-updated state.
    always_ff @(posedge avl_clk_i or negedge avl_reset_ni) begin
        if (!avl_reset_ni) begin
            state           <= CFG_WR;
            avl_address_o   <= ADDR_STATUS;
            avl_writedata_o <= '0;
            avl_write_o     <= 1'b0;
            avl_read_o      <= 1'b0;
            tx_ready_o      <= 1'b0;
            rx_data_o       <= '0;
            rx_valid_o      <= 1'b0;
            cfg_value       <= CFG_DEFAULT;
            cfg_pending     <= 1'b1;
            tx_full         <= 1'b0;
            rx_avail        <= 1'b0;
            rr_rx           <= 1'b0;
`ifdef AVL_RDV_TIMEOUT_EN
            tmo_cnt         <= '0;
            error_o         <= 1'b0;
`endif
        end else begin
            // Single-cycle strobes default low.
            avl_read_o <= 1'b0;
            tx_ready_o <= 1'b0;

            if (rx_valid_o && rx_ready_i)
                rx_valid_o <= 1'b0;

            case (state)
                CFG_WR: begin
                    if (!avl_write_o) begin
                        // Snapshot the value so it stays stable under
                        // waitrequest; a load arriving later re-arms pending.
                        avl_write_o     <= 1'b1;
                        avl_address_o   <= ADDR_CFG;
                        avl_writedata_o <= cfg_value;
                        cfg_pending     <= 1'b0;
                    end else if (!avl_waitrequest_i) begin
                        avl_write_o <= 1'b0;
                        state       <= POLL_RD;
                    end
                end
                POLL_RD: begin
                    avl_read_o    <= 1'b1;
                    avl_address_o <= ADDR_STATUS;
                    state         <= POLL_WAIT;
`ifdef AVL_RDV_TIMEOUT_EN
                    tmo_cnt       <= '0;
`endif
                end
                POLL_WAIT: begin
                    if (avl_readdatavalid_i) begin
                        tx_full  <= avl_readdata_i[3];
                        rx_avail <= avl_readdata_i[2];
                        state    <= DECIDE;
                    end
`ifdef AVL_RDV_TIMEOUT_EN
                    else if (tmo_hit) begin
                        error_o <= 1'b1;
                        state   <= POLL_RD;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end
                DECIDE: begin
                    if (cfg_pending) begin
                        state <= CFG_WR;
                    end else if (tx_elig && (!rx_elig || !rr_rx)) begin
                        avl_write_o     <= 1'b1;
                        avl_address_o   <= ADDR_TX;
                        avl_writedata_o <= 32'(tx_data_i);
                        tx_ready_o      <= 1'b1;
                        if (rx_elig)
                            rr_rx <= 1'b1;
                        state <= TX_WR;
                    end else if (rx_elig) begin
                        if (tx_elig)
                            rr_rx <= 1'b0;
                        state <= RX_RD;
                    end else begin
                        state <= POLL_RD;
                    end
                end
                TX_WR: begin
                    if (!avl_waitrequest_i) begin
                        avl_write_o <= 1'b0;
                        state       <= POLL_RD;
                    end
                end
                RX_RD: begin
                    avl_read_o    <= 1'b1;
                    avl_address_o <= ADDR_RX;
                    state         <= RX_WAIT;
`ifdef AVL_RDV_TIMEOUT_EN
                    tmo_cnt       <= '0;
`endif
                end
                RX_WAIT: begin
                    if (avl_readdatavalid_i) begin
                        rx_data_o  <= avl_readdata_i[DATASIZE-1:0];
                        rx_valid_o <= 1'b1;
                        state      <= POLL_RD;
                    end
`ifdef AVL_RDV_TIMEOUT_EN
                    else if (tmo_hit) begin
                        error_o <= 1'b1;
                        state   <= POLL_RD;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end
                default: state <= POLL_RD;
            endcase

            // A load may arrive in any state; last value wins.
            if (cfg_load_i) begin
                cfg_value   <= cfg_data_i;
                cfg_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avl_uart_master.sv
// ---------------------------------------------------------------------------
// tb_avl_uart_master
//
// Directed bench for avl_uart_master. A behavioural Avalon slave answers
// reads one cycle after the read strobe (status or RX word by address),
// inserts a programmable number of waitrequest cycles on writes and logs
// every completed command. A vector table covers single decisions; hand
// sequences cover waitrequest hold, RX back-pressure, round-robin, tx_full,
// config reload during a stalled write, timeout (when compiled in) and reset
// in the middle of a transfer.
// ---------------------------------------------------------------------------
module tb_avl_uart_master;

    localparam int OP_NONE = 0;
    localparam int OP_TX   = 1;
    localparam int OP_RX   = 2;
    localparam int OP_CFG  = 3;
    localparam int OP_BAD  = 9;

    typedef struct {
        bit          is_wr;
        logic [13:0] addr;
        logic [31:0] data;
        int          len;
    } cmd_t;

    typedef struct {
        logic [3:0]  status;
        logic        txv;
        logic [19:0] txd;
        logic [31:0] rxw;
        int          op;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        write;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        readdatavalid;
    logic [19:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [19:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] cfg_data;
    logic        cfg_load;
    logic        busy;
    logic        error;

    avl_uart_master dut (
        .avl_clk_i           (clk),
        .avl_reset_ni        (rst_n),
        .avl_address_o       (address),
        .avl_byteenable_o    (byteenable),
        .avl_writedata_o     (writedata),
        .avl_write_o         (write),
        .avl_read_o          (read),
        .avl_readdata_i      (readdata),
        .avl_waitrequest_i   (waitrequest),
        .avl_readdatavalid_i (readdatavalid),
        .tx_data_i           (tx_data),
        .tx_valid_i          (tx_valid),
        .tx_ready_o          (tx_ready),
        .rx_data_o           (rx_data),
        .rx_valid_o          (rx_valid),
        .rx_ready_i          (rx_ready),
        .cfg_data_i          (cfg_data),
        .cfg_load_i          (cfg_load),
        .busy_o              (busy),
        .error_o             (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Slave model state.
    logic [3:0]  status   = 4'b0001;
    logic [31:0] rx_word  = 32'h0;
    int          wait_cfg = 0;
    bit          withhold = 1'b0;
    cmd_t        log_q[$];
    int          viol     = 0;
    int          txr_cnt  = 0;

    bit          rd_pend;
    logic [13:0] rd_addr;
    int          wr_len;
    int          wait_left;
    bit          prev_wait;
    logic [13:0] prev_addr;
    logic [31:0] prev_data;

    initial begin
        readdata      = 32'h0;
        readdatavalid = 1'b0;
        waitrequest   = 1'b0;
    end

    // Slave responder and bus-rule monitor, all evaluated on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            readdatavalid = 1'b0;
            waitrequest   = 1'b0;
            rd_pend       = 1'b0;
            wr_len        = 0;
            wait_left     = 0;
            prev_wait     = 1'b0;
        end else begin
            if (read && write)                viol++;
            if (address > 14'd3)              viol++;
            if (byteenable != 4'hF)           viol++;
            if (write && prev_wait &&
                (address != prev_addr || writedata != prev_data)) viol++;
            if (tx_ready) txr_cnt++;

            readdatavalid = 1'b0;
            if (rd_pend) begin
                rd_pend = 1'b0;
                if (!withhold) begin
                    readdatavalid = 1'b1;
                    readdata = (rd_addr == 14'd0) ? {28'h0, status} :
                               (rd_addr == 14'd2) ? rx_word : 32'hDEAD_BEEF;
                    log_q.push_back('{1'b0, rd_addr, readdata, 1});
                end
            end
            if (read) begin
                rd_pend = 1'b1;
                rd_addr = address;
            end

            waitrequest = 1'b0;
            if (write) begin
                if (wr_len == 0) wait_left = wait_cfg;
                wr_len++;
                if (wait_left > 0) begin
                    waitrequest = 1'b1;
                    wait_left--;
                end else begin
                    log_q.push_back('{1'b1, address, writedata, wr_len});
                end
            end else begin
                wr_len = 0;
            end
            prev_wait = waitrequest;
            prev_addr = address;
            prev_data = writedata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int op_of(input cmd_t c);
        if (c.is_wr) return (c.addr == 14'd1) ? OP_TX : (c.addr == 14'd3) ? OP_CFG : OP_BAD;
        return (c.addr == 14'd2) ? OP_RX : (c.addr == 14'd0) ? OP_NONE : OP_BAD;
    endfunction

    task automatic get_cmd(output cmd_t c);
        bit got = 1'b0;
        c = '{1'b0, 14'h3FFF, 32'h0, 0};
        for (int i = 0; i < 300; i++) begin
            if (log_q.size() > 0) begin
                c   = log_q.pop_front();
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) check("cmd_timeout", 32'd0, 32'd1);
    endtask

    // Wait for the next fresh status poll, present the TX request just in
    // time for the decision that follows it, and return the next command.
    task automatic decide(input logic txv, input logic [19:0] txd, output cmd_t c);
        log_q.delete();
        tx_data = txd;
        for (int i = 0; i < 10; i++) begin
            get_cmd(c);
            if (!c.is_wr && c.addr == 14'd0) break;
        end
        tx_valid = txv;
        get_cmd(c);
    endtask

    task automatic next_op(output cmd_t c);
        for (int i = 0; i < 20; i++) begin
            get_cmd(c);
            if (c.is_wr || c.addr != 14'd0) break;
        end
    endtask

    task automatic next_wr(output cmd_t c);
        for (int i = 0; i < 20; i++) begin
            get_cmd(c);
            if (c.is_wr) break;
        end
    endtask

    task automatic wait_rx();
        for (int i = 0; i < 30 && !rx_valid; i++) @(negedge clk);
        check("rx_valid_set", 32'(rx_valid), 32'd1);
    endtask

    task automatic take_rx();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("rx_valid_cleared", 32'(rx_valid), 32'd0);
    endtask

    task automatic count_log(input bit wr, input logic [13:0] a, output int n);
        n = 0;
        foreach (log_q[i]) if (log_q[i].is_wr == wr && log_q[i].addr == a) n++;
    endtask

    vec_t tbl[7];
    cmd_t c;
    int   txr0;
    int   n;

    initial begin
        tbl[0] = '{4'b0001, 1'b1, 20'h00001, 32'h0,         OP_TX,   32'h0000_0001};
        tbl[1] = '{4'b0001, 1'b1, 20'hFFFFF, 32'h0,         OP_TX,   32'h000F_FFFF};
        tbl[2] = '{4'b1001, 1'b1, 20'h00005, 32'h0,         OP_NONE, 32'h0};
        tbl[3] = '{4'b0100, 1'b0, 20'h0,     32'hFFF1_2345, OP_RX,   32'h0001_2345};
        tbl[4] = '{4'b0110, 1'b0, 20'h0,     32'h000A_BCDE, OP_RX,   32'h000A_BCDE};
        tbl[5] = '{4'b0001, 1'b0, 20'h0,     32'h0,         OP_NONE, 32'h0};
        tbl[6] = '{4'b1111, 1'b1, 20'h00099, 32'h0000_0077, OP_RX,   32'h0000_0077};

        rst_n    = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        cfg_data = '0;
        cfg_load = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_strobes", {28'h0, write, read, tx_ready, rx_valid}, 32'h0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_address", 32'(address), 32'd0);
        check("rst_writedata", writedata, 32'h0);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_busy", 32'(busy), 32'd1);
        log_q.delete();
        rst_n = 1'b1;

        // First command: config write, one cycle, then a status read.
        get_cmd(c);
        check("boot_op", op_of(c), OP_CFG);
        check("boot_data", c.data, 32'h0000_01B2);
        check("boot_len", c.len, 1);
        get_cmd(c);
        check("boot_poll", op_of(c), OP_NONE);

        // Vector table: one decision each, always starting from idle.
        foreach (tbl[i]) begin
            status  = tbl[i].status;
            rx_word = tbl[i].rxw;
            decide(tbl[i].txv, tbl[i].txd, c);
            tx_valid = 1'b0;
            check($sformatf("vec%0d_op", i), op_of(c), tbl[i].op);
            if (tbl[i].op == OP_TX) begin
                check($sformatf("vec%0d_txdata", i), c.data, tbl[i].exp);
            end else if (tbl[i].op == OP_RX) begin
                wait_rx();
                check($sformatf("vec%0d_rxdata", i), 32'(rx_data), tbl[i].exp);
                status = 4'b0001;
                repeat (12) @(negedge clk);
                take_rx();
            end
            status = 4'b0001;
            repeat (8) @(negedge clk);
        end

        // TX write held through three waitrequest cycles.
        wait_cfg = 3;
        txr0     = txr_cnt;
        decide(1'b1, 20'hABCDE, c);
        tx_valid = 1'b0;
        check("hold_op", op_of(c), OP_TX);
        check("hold_data", c.data, 32'h000A_BCDE);
        check("hold_len", c.len, 4);
        check("hold_tx_ready", txr_cnt - txr0, 1);
        wait_cfg = 0;
        repeat (8) @(negedge clk);

        // RX word held under back-pressure; no further RX read meanwhile.
        status  = 4'b0100;
        rx_word = 32'hFFF1_2345;
        decide(1'b0, 20'h0, c);
        check("bp_op", op_of(c), OP_RX);
        wait_rx();
        check("bp_rxdata", 32'(rx_data), 32'h0001_2345);
        log_q.delete();
        repeat (30) @(negedge clk);
        count_log(1'b0, 14'd2, n);
        check("bp_no_rx_read", n, 0);
        count_log(1'b0, 14'd0, n);
        check("bp_polling", 32'(n >= 2), 32'd1);
        check("bp_rx_held", 32'(rx_valid), 32'd1);
        status = 4'b0001;
        repeat (12) @(negedge clk);
        take_rx();
        repeat (8) @(negedge clk);

        // tx_full blocks TX writes; polling continues.
        status = 4'b1000;
        repeat (10) @(negedge clk);
        txr0 = txr_cnt;
        log_q.delete();
        tx_data  = 20'h12121;
        tx_valid = 1'b1;
        repeat (40) @(negedge clk);
        tx_valid = 1'b0;
        count_log(1'b1, 14'd1, n);
        check("full_no_tx", n, 0);
        check("full_tx_ready", txr_cnt - txr0, 0);
        count_log(1'b0, 14'd0, n);
        check("full_polling", 32'(n >= 2), 32'd1);
        status = 4'b0001;
        repeat (10) @(negedge clk);

        // Round-robin: both eligible on every poll -> TX, RX, TX, RX.
        status   = 4'b0101;
        rx_word  = 32'h0000_0ABC;
        rx_ready = 1'b1;
        decide(1'b1, 20'h22222, c);
        check("rr_0", op_of(c), OP_TX);
        next_op(c);
        check("rr_1", op_of(c), OP_RX);
        next_op(c);
        check("rr_2", op_of(c), OP_TX);
        next_op(c);
        check("rr_3", op_of(c), OP_RX);
        tx_valid = 1'b0;
        status   = 4'b0001;
        repeat (20) @(negedge clk);
        rx_ready = 1'b0;
        check("rr_rx_drained", 32'(rx_valid), 32'd0);

        // Config loads during a stalled TX write: TX finishes, then 0x55.
        wait_cfg = 4;
        log_q.delete();
        tx_data  = 20'h00777;
        tx_valid = 1'b1;
        for (int i = 0; i < 100 && !(write && address == 14'd1); i++) @(negedge clk);
        tx_valid = 1'b0;
        cfg_data = 32'h0000_0033;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_data = 32'h0000_0055;
        @(negedge clk);
        cfg_load = 1'b0;
        next_wr(c);
        check("cfgld_tx_first", op_of(c), OP_TX);
        check("cfgld_tx_data", c.data, 32'h0000_0777);
        next_wr(c);
        check("cfgld_cfg_op", op_of(c), OP_CFG);
        check("cfgld_cfg_data", c.data, 32'h0000_0055);
        wait_cfg = 0;
        repeat (10) @(negedge clk);

`ifdef AVL_RDV_TIMEOUT_EN
        // Withheld readdatavalid -> sticky error, polling resumes.
        check("tmo_error_before", 32'(error), 32'd0);
        withhold = 1'b1;
        repeat (60) @(negedge clk);
        check("tmo_error_set", 32'(error), 32'd1);
        withhold = 1'b0;
        decide(1'b0, 20'h0, c);
        check("tmo_poll_resumes", op_of(c), OP_NONE);
        check("tmo_error_sticky", 32'(error), 32'd1);
`endif

        // Reset in the middle of a stalled TX write.
        wait_cfg = 10;
        tx_data  = 20'h0F0F0;
        tx_valid = 1'b1;
        for (int i = 0; i < 100 && !(write && address == 14'd1); i++) @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        txr0 = txr_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_strobes", {29'h0, write, read, tx_ready}, 32'h0);
        repeat (2) @(negedge clk);
        log_q.delete();
        wait_cfg = 0;
        rst_n    = 1'b1;
        get_cmd(c);
        check("midrst_cfg", op_of(c), OP_CFG);
        check("midrst_cfg_data", c.data, 32'h0000_01B2);
        check("midrst_no_ready", txr_cnt - txr0, 0);
        check("midrst_error", 32'(error), 32'd0);

        repeat (10) @(negedge clk);
        check("bus_rules", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
